vram_arbiter: RTL and testbench

//  Shares the single-port video RAM between the VDP display fetch and CPU accesses, on dot_clk.

---
 rtl/vdp_pkg.sv | 22 ++
 rtl/vram_post_buffer.sv | 49 ++++
 rtl/vram_arbiter.sv | 141 ++++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP VRAM arbiter and its posted-write buffer.
// Optional posted-write support is enabled by defining VRAM_POST_WRITE_EN.
package vdp_pkg;

   localparam int SLOT_COUNT = 8;
   localparam int SLOT_W     = $clog2(SLOT_COUNT);
   localparam int DEF_SLOT_A = 0;
   localparam int DEF_SLOT_B = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_ACK  = 1'b1
   } arb_state_t;

   typedef logic [SLOT_W-1:0] slot_t;

   // Slot counter advance; wraps at the end of the 8-dot window.
   function automatic slot_t slot_next(input slot_t s);
      return (s == slot_t'(SLOT_COUNT - 1)) ? '0 : s + 1'b1;
   endfunction

endpackage

// File: rtl/vram_post_buffer.sv
// One-entry posted-write buffer for the VRAM arbiter (used only with VRAM_POST_WRITE_EN).
// Holds a CPU write until the first non-display slot, when it is drained to the BRAM.
module vram_post_buffer
   import vdp_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              dot_clk,
   input  logic              reset,
   input  logic              i_owned,
   input  logic              i_capture,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              o_full,
   output logic              o_drain,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;

   // NOTE: only the valid flag is reset; address and data are qualified by it,
   // so clearing them would add reset fan-out for no functional benefit.
   always_ff @(posedge dot_clk) begin
      if (reset) begin
         r_valid <= 1'b0;
      end else if (i_capture) begin
         r_valid <= 1'b1;
      end else if (o_drain) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge dot_clk) begin
      if (i_capture) begin
         r_addr  <= i_addr;
         r_wdata <= i_wdata;
      end
   end

   assign o_full  = r_valid;
   assign o_drain = r_valid && !i_owned && !reset;
   assign o_addr  = r_addr;
   assign o_wdata = r_wdata;

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between display fetch (two fixed slots per 8-dot window)
// and CPU req/ack accesses. Define VRAM_POST_WRITE_EN for the one-entry posted-write buffer.
module vram_arbiter
   import vdp_pkg::*;
#(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8,
   parameter int SLOT_A = DEF_SLOT_A,
   parameter int SLOT_B = DEF_SLOT_B
) (
   input  logic              dot_clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_valid,
   output logic [DATA_W-1:0] disp_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam slot_t L_SLOT_A = slot_t'(SLOT_A);
   localparam slot_t L_SLOT_B = slot_t'(SLOT_B);

   slot_t             r_slot;
   arb_state_t        r_state;
   logic              r_disp_valid;
   logic              r_rd_pend;
   logic [DATA_W-1:0] r_cpu_rdata;

   slot_t             w_slot;
   logic              w_owned;
   logic              w_grant;
   logic              w_cpu_mem;
   logic              w_drain;
   logic [ADDR_W-1:0] w_drain_addr;
   logic [DATA_W-1:0] w_drain_wdata;

   // A line_start cycle is treated as slot 0 so the window realigns without a lost slot.
   assign w_slot  = line_start ? '0 : r_slot;
   assign w_owned = !reset && fetch_en && (w_slot == L_SLOT_A || w_slot == L_SLOT_B);

`ifdef VRAM_POST_WRITE_EN
   logic w_full;
   logic w_capture;

   // A full buffer blocks every CPU access, so reads never overtake a pending write.
   assign w_grant   = !reset && cpu_req && (r_state == ARB_IDLE) && !w_owned && !w_full;
   assign w_capture = w_grant && cpu_we;
   assign w_cpu_mem = w_grant && !cpu_we;

   vram_post_buffer #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_post_buffer (
      .dot_clk   (dot_clk),
      .reset     (reset),
      .i_owned   (w_owned),
      .i_capture (w_capture),
      .i_addr    (cpu_addr),
      .i_wdata   (cpu_wdata),
      .o_full    (w_full),
      .o_drain   (w_drain),
      .o_addr    (w_drain_addr),
      .o_wdata   (w_drain_wdata)
   );
`else
   assign w_grant       = !reset && cpu_req && (r_state == ARB_IDLE) && !w_owned;
   assign w_cpu_mem     = w_grant;
   assign w_drain       = 1'b0;
   assign w_drain_addr  = '0;
   assign w_drain_wdata = '0;
`endif

   // Port mux: display > posted-write drain > CPU; idle cycles present address 0.
   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (w_owned) begin
         mem_addr = disp_addr;
      end else if (w_drain) begin
         mem_addr  = w_drain_addr;
         mem_we    = 1'b1;
         mem_wdata = w_drain_wdata;
      end else if (w_cpu_mem) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_wdata;
      end
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge dot_clk) begin
      if (reset) begin
         r_slot       <= '0;
         r_state      <= ARB_IDLE;
         r_disp_valid <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_cpu_rdata  <= '0;
      end else begin
         r_slot       <= slot_next(w_slot);
         r_disp_valid <= w_owned;
         case (r_state)
            ARB_IDLE: begin
               if (w_grant) begin
                  r_state   <= ARB_ACK;
                  r_rd_pend <= !cpu_we;
               end
            end
            ARB_ACK: begin
               r_state   <= ARB_IDLE;
               r_rd_pend <= 1'b0;
               if (r_rd_pend) begin
                  r_cpu_rdata <= mem_rdata;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   // Reset is synchronous, so registered outputs are masked while it is high;
   // this drops an in-flight ack in the reset cycle itself.
   assign cpu_ack    = (r_state == ARB_ACK) && !reset;
   assign disp_valid = r_disp_valid && !reset;
   assign disp_rdata = mem_rdata;
   assign cpu_rdata  = reset                    ? '0        :
                       (cpu_ack && r_rd_pend)   ? mem_rdata :
                                                  r_cpu_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a BRAM model and scoreboards.
// The posted-write scenario runs only when VRAM_POST_WRITE_EN is defined.
module tb_vram_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   logic              dot_clk    = 1'b0;
   logic              reset      = 1'b1;
   logic              line_start = 1'b0;
   logic              fetch_en   = 1'b0;
   logic [ADDR_W-1:0] disp_addr  = '0;
   logic              cpu_req    = 1'b0;
   logic              cpu_we     = 1'b0;
   logic [ADDR_W-1:0] cpu_addr   = '0;
   logic [DATA_W-1:0] cpu_wdata  = '0;
   logic              disp_valid;
   logic [DATA_W-1:0] disp_rdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] bram [0:(1<<ADDR_W)-1];

   typedef struct packed {
      logic              is_read;
      logic [DATA_W-1:0] data;
   } cpu_exp_t;

   cpu_exp_t          cpu_q[$];
   logic [DATA_W-1:0] disp_q[$];

   int vectors      = 0;
   int fails        = 0;
   int cyc          = 0;
   int last_ack_cyc = 0;
   int t_first      = 0;

   logic [2:0]        m_slot = 3'd0;
   logic [2:0]        m_eff;
   logic              m_own;
   logic              m_dv   = 1'b0;
   logic [DATA_W-1:0] d_exp;
   cpu_exp_t          c_exp;

   always #5 dot_clk = ~dot_clk;

   vram_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SLOT_A (0),
      .SLOT_B (4)
   ) dut (
      .dot_clk    (dot_clk),
      .reset      (reset),
      .line_start (line_start),
      .fetch_en   (fetch_en),
      .disp_addr  (disp_addr),
      .disp_valid (disp_valid),
      .disp_rdata (disp_rdata),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Synchronous BRAM, read-before-write, one cycle read latency.
   always @(posedge dot_clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   // Display slot model: queues the data the display should see the cycle after each owned slot.
   always @(posedge dot_clk) begin
      cyc   <= cyc + 1;
      m_eff  = line_start ? 3'd0 : m_slot;
      m_own  = !reset && fetch_en && (m_eff == 3'd0 || m_eff == 3'd4);
      if (m_own) disp_q.push_back(bram[disp_addr]);
      m_dv   <= m_own;
      m_slot <= reset ? 3'd0 : m_eff + 3'd1;
   end

   always @(negedge dot_clk) begin
      vectors++;
      assert (disp_valid === (m_dv && !reset)) else begin
         fails++;
         $error("FAIL disp_valid: observed %b expected %b", disp_valid, m_dv && !reset);
      end
      if (m_dv && disp_q.size() > 0) begin
         d_exp = disp_q.pop_front();
         if (!reset) begin
            vectors++;
            assert (disp_rdata === d_exp) else begin
               fails++;
               $error("FAIL disp_rdata: observed %0h expected %0h", disp_rdata, d_exp);
            end
         end
      end
   end

   always @(negedge dot_clk) begin
      if (cpu_ack !== 1'b0) begin
         vectors++;
         assert (cpu_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_ack: observed cpu_ack=%b expected no ack", cpu_ack);
         end
         if (cpu_q.size() != 0) begin
            c_exp = cpu_q.pop_front();
            if (c_exp.is_read) begin
               vectors++;
               assert (cpu_rdata === c_exp.data) else begin
                  fails++;
                  $error("FAIL cpu_rdata_sb: observed %0h expected %0h", cpu_rdata, c_exp.data);
               end
            end
         end
      end
   end

   function automatic logic [DATA_W-1:0] pat(input int a);
      return DATA_W'(a) ^ 8'h5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge dot_clk);
      #2;
   endtask

   task automatic sample();
      @(negedge dot_clk);
   endtask

   task automatic cpu_issue(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_q.push_back('{is_read: !we, data: (we ? '0 : exp_rd)});
   endtask

   // Counts cycles from request to ack (bounded), then drops the request after the ack cycle.
   task automatic wait_ack(input string tag, input int exp_lat);
      int n = 0;
      sample();
      while (cpu_ack !== 1'b1 && n < 16) begin
         sample();
         n++;
      end
      last_ack_cyc = cyc;
      check(tag, 32'(n), 32'(exp_lat));
      next();
      cpu_req = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) bram[i] = pat(i);

      // Reset values
      next();
      next();
      sample();
      check("rst_ack",   32'(cpu_ack),    0);
      check("rst_dv",    32'(disp_valid), 0);
      check("rst_rdata", 32'(cpu_rdata),  0);
      check("rst_we",    32'(mem_we),     0);
      check("rst_addr",  32'(mem_addr),   0);
      next();
      reset = 1'b0;

      // 1: display fetch owns slots 0 and 4
      fetch_en   = 1'b1;
      disp_addr  = 13'h100;
      line_start = 1'b1;
      sample();
      check("t1_addr_s0", 32'(mem_addr), 32'h100);
      check("t1_we_s0",   32'(mem_we),   0);
      next();
      line_start = 1'b0;
      for (int s = 1; s < 8; s++) begin
         sample();
         check("t1_addr", 32'(mem_addr), (s == 4) ? 32'h100 : 32'h0);
         check("t1_dv",   32'(disp_valid), (s == 1 || s == 5) ? 32'd1 : 32'd0);
         next();
      end

      // 2: CPU read at slot 0 waits one slot, acks at slot 2
      line_start = 1'b1;
      cpu_issue(1'b0, 13'h042, 8'h00, pat(32'h42));
      sample();
      check("t2_owned_addr", 32'(mem_addr), 32'h100);
      next();
      line_start = 1'b0;
      sample();
      check("t2_grant_addr", 32'(mem_addr), 32'h042);
      check("t2_no_ack",     32'(cpu_ack),  0);
      next();
      sample();
      check("t2_ack",   32'(cpu_ack),   1);
      check("t2_rdata", 32'(cpu_rdata), 32'(pat(32'h42)));
      next();
      cpu_req = 1'b0;

      // 3: outside window, back-to-back writes then read-back
      fetch_en = 1'b0;
      cpu_issue(1'b1, 13'h010, 8'hAA, 8'h00);
      wait_ack("t3_w1_lat", 1);
      t_first = last_ack_cyc;
      cpu_issue(1'b1, 13'h011, 8'hBB, 8'h00);
      wait_ack("t3_w2_lat", 1);
      check("t3_ack_gap", 32'(last_ack_cyc - t_first), 2);
      cpu_issue(1'b0, 13'h010, 8'h00, 8'hAA);
      wait_ack("t3_r1_lat", 1);
      cpu_issue(1'b0, 13'h011, 8'h00, 8'hBB);
      wait_ack("t3_r2_lat", 1);
      repeat (3) next();
      sample();
      check("t3_hold", 32'(cpu_rdata), 32'hBB);
      next();
      cpu_issue(1'b1, 13'h012, 8'hCC, 8'h00);
      wait_ack("t3_w3_lat", 1);
      sample();
      check("t3_hold_wr", 32'(cpu_rdata), 32'hBB);

      // 5: reset the cycle after a read grant drops the ack
      next();
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 13'h050;
      sample();
      check("t5_grant_addr", 32'(mem_addr), 32'h050);
      next();
      reset   = 1'b1;
      cpu_req = 1'b0;
      sample();
      check("t5_ack_rst",   32'(cpu_ack),    0);
      check("t5_we_rst",    32'(mem_we),     0);
      check("t5_addr_rst",  32'(mem_addr),   0);
      check("t5_rdata_rst", 32'(cpu_rdata),  0);
      next();
      reset = 1'b0;
      sample();
      check("t5_ack_after",   32'(cpu_ack),   0);
      check("t5_rdata_after", 32'(cpu_rdata), 0);
      check("t5_we_after",    32'(mem_we),    0);

      // 6: line_start during the ack cycle realigns slots without losing the ack
      next();
      fetch_en   = 1'b1;
      disp_addr  = 13'h1A3;
      line_start = 1'b1;
      sample();
      check("t6_s0", 32'(mem_addr), 32'h1A3);
      next();
      line_start = 1'b0;
      repeat (5) next();
      cpu_issue(1'b0, 13'h077, 8'h00, pat(32'h77));
      sample();
      check("t6_grant", 32'(mem_addr), 32'h077);
      next();
      line_start = 1'b1;
      sample();
      check("t6_ack",     32'(cpu_ack),   1);
      check("t6_realign", 32'(mem_addr),  32'h1A3);
      check("t6_rdata",   32'(cpu_rdata), 32'(pat(32'h77)));
      next();
      line_start = 1'b0;
      cpu_req    = 1'b0;
      sample();
      check("t6_dv", 32'(disp_valid), 1);
      repeat (3) next();
      sample();
      check("t6_s4", 32'(mem_addr), 32'h1A3);

`ifdef VRAM_POST_WRITE_EN
      // 4: posted write at slot 3, read stalls behind the drain at slot 5
      next();
      line_start = 1'b1;
      next();
      line_start = 1'b0;
      next();
      next();
      cpu_issue(1'b1, 13'h020, 8'h55, 8'h00);
      sample();
      check("t4_capture_we", 32'(mem_we), 0);
      next();
      sample();
      check("t4_wr_ack", 32'(cpu_ack),  1);
      check("t4_owned",  32'(mem_addr), 32'h1A3);
      next();
      cpu_issue(1'b0, 13'h020, 8'h00, 8'h55);
      sample();
      check("t4_drain_we",    32'(mem_we),    1);
      check("t4_drain_addr",  32'(mem_addr),  32'h020);
      check("t4_drain_wdata", 32'(mem_wdata), 32'h55);
      check("t4_stall_ack",   32'(cpu_ack),   0);
      next();
      sample();
      check("t4_rd_grant", 32'(mem_addr), 32'h020);
      check("t4_rd_we",    32'(mem_we),   0);
      next();
      sample();
      check("t4_rd_ack",   32'(cpu_ack),   1);
      check("t4_rd_rdata", 32'(cpu_rdata), 32'h55);
      next();
      cpu_req = 1'b0;
`endif

      fetch_en = 1'b0;
      repeat (4) next();
      sample();
      check("sb_cpu_empty",  32'(cpu_q.size()),  0);
      check("sb_disp_empty", 32'(disp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
